// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side inputs, MEM/WB forwarding taps and EX-side outputs.
// The decode/hazard logic is the master side and the pipeline register is the slave side.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     stall;
  logic                     flush;
  logic [DATA_WIDTH-1:0]    id_pc;
  logic [DATA_WIDTH-1:0]    id_rd1;
  logic [DATA_WIDTH-1:0]    id_rd2;
  logic [DATA_WIDTH-1:0]    id_imm;
  logic [4:0]               id_rs1;
  logic [4:0]               id_rs2;
  logic [4:0]               id_rd;
  logic [OPCODE_LENGTH-1:0] id_alu_op;
  logic                     id_asel_pc;
  logic                     id_bsel_imm;
  logic                     id_regwrite;
  logic [4:0]               mem_fwd_rd;
  logic                     mem_fwd_we;
  logic [DATA_WIDTH-1:0]    mem_fwd_data;
  logic [4:0]               wb_fwd_rd;
  logic                     wb_fwd_we;
  logic [DATA_WIDTH-1:0]    wb_fwd_data;
  logic                     ex_valid;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    ex_pc;
  logic [4:0]               ex_rd;
  logic                     ex_regwrite;
  logic [DATA_WIDTH-1:0]    ex_store_data;

  modport master (
    output stall, flush,
    output id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
    output id_alu_op, id_asel_pc, id_bsel_imm, id_regwrite,
    output mem_fwd_rd, mem_fwd_we, mem_fwd_data,
    output wb_fwd_rd, wb_fwd_we, wb_fwd_data,
    input  ex_valid, SrcA, SrcB, Operation, ex_pc, ex_rd, ex_regwrite, ex_store_data
  );

  modport slave (
    input  stall, flush,
    input  id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
    input  id_alu_op, id_asel_pc, id_bsel_imm, id_regwrite,
    input  mem_fwd_rd, mem_fwd_we, mem_fwd_data,
    input  wb_fwd_rd, wb_fwd_we, wb_fwd_data,
    output ex_valid, SrcA, SrcB, Operation, ex_pc, ex_rd, ex_regwrite, ex_store_data
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush and ALU operand selection.
// Define ID_EX_FORWARDING_EN to enable MEM/WB operand forwarding; otherwise the register-file values pass through.
module id_ex_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input logic           clk,
  input logic           reset,
  id_ex_stage_if.slave  bus
);

  logic                     valid_reg;
  logic [DATA_WIDTH-1:0]    pc_reg;
  logic [DATA_WIDTH-1:0]    rd1_reg;
  logic [DATA_WIDTH-1:0]    rd2_reg;
  logic [DATA_WIDTH-1:0]    imm_reg;
  logic [4:0]               rs1_reg;
  logic [4:0]               rs2_reg;
  logic [4:0]               rd_reg;
  logic [OPCODE_LENGTH-1:0] alu_op_reg;
  logic                     asel_pc_reg;
  logic                     bsel_imm_reg;
  logic                     regwrite_reg;

  // A bubble only kills the fields that can cause side effects; the data
  // fields keep their old contents since nothing downstream looks at them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      pc_reg       <= '0;
      rd1_reg      <= '0;
      rd2_reg      <= '0;
      imm_reg      <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      rd_reg       <= '0;
      alu_op_reg   <= '0;
      asel_pc_reg  <= 1'b0;
      bsel_imm_reg <= 1'b0;
      regwrite_reg <= 1'b0;
    end else if (bus.flush) begin
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      alu_op_reg   <= '0;
    end else if (!bus.stall) begin
      valid_reg    <= 1'b1;
      pc_reg       <= bus.id_pc;
      rd1_reg      <= bus.id_rd1;
      rd2_reg      <= bus.id_rd2;
      imm_reg      <= bus.id_imm;
      rs1_reg      <= bus.id_rs1;
      rs2_reg      <= bus.id_rs2;
      rd_reg       <= bus.id_rd;
      alu_op_reg   <= bus.id_alu_op;
      asel_pc_reg  <= bus.id_asel_pc;
      bsel_imm_reg <= bus.id_bsel_imm;
      regwrite_reg <= bus.id_regwrite;
    end
  end

  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;

  // Operand 0 resolves rs1, operand 1 resolves rs2; MEM is younger so it wins over WB.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [DATA_WIDTH-1:0] reg_val;
      logic [DATA_WIDTH-1:0] val;
      assign reg_val = (gi == 0) ? rd1_reg : rd2_reg;
`ifdef ID_EX_FORWARDING_EN
      logic [4:0] idx;
      assign idx = (gi == 0) ? rs1_reg : rs2_reg;
      always_comb begin
        val = reg_val;
        if (bus.mem_fwd_we && (bus.mem_fwd_rd != 5'd0) && (bus.mem_fwd_rd == idx)) begin
          val = bus.mem_fwd_data;
        end else if (bus.wb_fwd_we && (bus.wb_fwd_rd != 5'd0) && (bus.wb_fwd_rd == idx)) begin
          val = bus.wb_fwd_data;
        end
      end
`else
      assign val = reg_val;
`endif
    end
  endgenerate

  assign fwd_a = g_fwd[0].val;
  assign fwd_b = g_fwd[1].val;

`ifndef ID_EX_FORWARDING_EN
  logic unused_fwd;
  assign unused_fwd = ^{bus.mem_fwd_rd, bus.mem_fwd_we, bus.mem_fwd_data,
                        bus.wb_fwd_rd, bus.wb_fwd_we, bus.wb_fwd_data,
                        rs1_reg, rs2_reg};
`endif

  assign bus.ex_valid      = valid_reg;
  assign bus.SrcA          = asel_pc_reg  ? pc_reg  : fwd_a;
  assign bus.SrcB          = bsel_imm_reg ? imm_reg : fwd_b;
  assign bus.Operation     = alu_op_reg;
  assign bus.ex_pc         = pc_reg;
  assign bus.ex_rd         = rd_reg;
  assign bus.ex_regwrite   = regwrite_reg & valid_reg;
  assign bus.ex_store_data = fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed corner cases followed by
// randomized traffic checked against an instruction-level model of the EX slot.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int OL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) bus ();

  id_ex_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  // Contents of the EX slot as an instruction, not as registers.
  typedef struct {
    bit          valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    bit          asel, bsel, rw;
  } ex_t;
  ex_t m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] regv);
`ifdef ID_EX_FORWARDING_EN
    if (bus.mem_fwd_we && idx != 0 && bus.mem_fwd_rd == idx) return bus.mem_fwd_data;
    if (bus.wb_fwd_we && idx != 0 && bus.wb_fwd_rd == idx) return bus.wb_fwd_data;
`endif
    return regv;
  endfunction

  function automatic ex_t empty_slot();
    ex_t z;
    z.valid = 0; z.pc = 0; z.rd1 = 0; z.rd2 = 0; z.imm = 0;
    z.rs1 = 0; z.rs2 = 0; z.rd = 0; z.op = 0; z.asel = 0; z.bsel = 0; z.rw = 0;
    return z;
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] b_val;
    b_val = operand(m.rs2, m.rd2);
    chk({tag, ".ex_valid"},    {31'b0, bus.ex_valid},    {31'b0, m.valid});
    chk({tag, ".SrcA"},        bus.SrcA,                 m.asel ? m.pc : operand(m.rs1, m.rd1));
    chk({tag, ".SrcB"},        bus.SrcB,                 m.bsel ? m.imm : b_val);
    chk({tag, ".Operation"},   {28'b0, bus.Operation},   {28'b0, m.op});
    chk({tag, ".ex_pc"},       bus.ex_pc,                m.pc);
    chk({tag, ".ex_rd"},       {27'b0, bus.ex_rd},       {27'b0, m.rd});
    chk({tag, ".ex_regwrite"}, {31'b0, bus.ex_regwrite}, {31'b0, m.valid & m.rw});
    chk({tag, ".store_data"},  bus.ex_store_data,        b_val);
  endtask

  // One clock: the model takes the same decision the pipeline must take at this edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m = empty_slot();
    end else if (bus.flush) begin
      m.valid = 0; m.rw = 0; m.op = 0;
    end else if (!bus.stall) begin
      m.valid = 1;
      m.pc = bus.id_pc; m.rd1 = bus.id_rd1; m.rd2 = bus.id_rd2; m.imm = bus.id_imm;
      m.rs1 = bus.id_rs1; m.rs2 = bus.id_rs2; m.rd = bus.id_rd; m.op = bus.id_alu_op;
      m.asel = bus.id_asel_pc; m.bsel = bus.id_bsel_imm; m.rw = bus.id_regwrite;
    end
    #1;
  endtask

  task automatic set_id(input logic [31:0] pc, rd1, rd2, imm, input logic [4:0] rs1, rs2, rd,
                        input logic [3:0] op, input bit asel, bsel, rw);
    bus.id_pc = pc; bus.id_rd1 = rd1; bus.id_rd2 = rd2; bus.id_imm = imm;
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd; bus.id_alu_op = op;
    bus.id_asel_pc = asel; bus.id_bsel_imm = bsel; bus.id_regwrite = rw;
  endtask

  task automatic rand_id();
    set_id($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic set_fwd(input logic [4:0] mrd, input bit mwe, input logic [31:0] mdata,
                         input logic [4:0] wrd, input bit wwe, input logic [31:0] wdata);
    bus.mem_fwd_rd = mrd; bus.mem_fwd_we = mwe; bus.mem_fwd_data = mdata;
    bus.wb_fwd_rd = wrd; bus.wb_fwd_we = wwe; bus.wb_fwd_data = wdata;
  endtask

  logic [31:0] held_pc;

  initial begin
    m = empty_slot();
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check_all("reset");
    reset = 1'b0;

    // Plain register operands.
    set_id(32'h100, 5, 7, 32'h40, 1, 2, 4, 4'b0010, 0, 0, 1);
    tick();
    chk("basic.SrcA", bus.SrcA, 32'd5);
    chk("basic.SrcB", bus.SrcB, 32'd7);
    chk("basic.Operation", {28'b0, bus.Operation}, 32'h2);
    chk("basic.ex_valid", {31'b0, bus.ex_valid}, 32'd1);
    check_all("basic");

    // Immediate and PC operand selects; store data still carries rs2.
    set_id(32'h200, 9, 7, 32'h40, 1, 2, 4, 4'b0001, 1, 1, 1);
    tick();
    chk("sel.SrcA_pc", bus.SrcA, 32'h200);
    chk("sel.SrcB_imm", bus.SrcB, 32'h40);
    chk("sel.store", bus.ex_store_data, 32'd7);

    // Forwarding priority and the x0 exemption.
    set_id(32'h300, 32'h99, 32'h77, 0, 3, 4, 5, 4'b0000, 0, 0, 1);
    tick();
    set_fwd(3, 1, 32'h11, 3, 1, 32'h22);
    #1;
`ifdef ID_EX_FORWARDING_EN
    chk("fwd.mem_wins", bus.SrcA, 32'h11);
`else
    chk("fwd.disabled", bus.SrcA, 32'h99);
`endif
    check_all("fwd_both");
    bus.mem_fwd_we = 1'b0;
    #1;
`ifdef ID_EX_FORWARDING_EN
    chk("fwd.wb_only", bus.SrcA, 32'h22);
`else
    chk("fwd.disabled_wb", bus.SrcA, 32'h99);
`endif
    check_all("fwd_wb");
    set_id(32'h304, 32'h55, 32'h66, 0, 0, 0, 5, 4'b0000, 0, 0, 1);
    set_fwd(0, 1, 32'h11, 0, 1, 32'h22);
    tick();
    chk("fwd.x0", bus.SrcA, 32'h55);
    chk("fwd.x0_store", bus.ex_store_data, 32'h66);
    set_fwd(0, 0, 0, 0, 0, 0);

    // Flush beats stall.
    set_id(32'h400, 1, 2, 3, 1, 2, 6, 4'b0110, 0, 0, 1);
    tick();
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    tick();
    chk("flush.ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("flush.regwrite", {31'b0, bus.ex_regwrite}, 32'd0);
    chk("flush.Operation", {28'b0, bus.Operation}, 32'd0);
    check_all("flush");
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // Stall for three cycles while decode keeps changing.
    set_id(32'h500, 11, 12, 13, 1, 2, 7, 4'b0011, 0, 1, 1);
    tick();
    held_pc = 32'h500;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      tick();
      chk("stall.ex_pc", bus.ex_pc, held_pc);
      check_all("stall");
    end
    bus.stall = 1'b0;
    bus.id_pc = 32'h600;
    tick();
    chk("release.ex_pc", bus.ex_pc, 32'h600);
    check_all("release");

    // Reset arriving mid-stall clears immediately and the held instruction is lost.
    bus.stall = 1'b1;
    tick();
    reset = 1'b1;
    m = empty_slot();
    #1;
    chk("rst_async.ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("rst_async.ex_pc", bus.ex_pc, 32'd0);
    chk("rst_async.Operation", {28'b0, bus.Operation}, 32'd0);
    chk("rst_async.ex_rd", {27'b0, bus.ex_rd}, 32'd0);
    chk("rst_async.ex_regwrite", {31'b0, bus.ex_regwrite}, 32'd0);
    check_all("rst_async");
    tick();
    reset = 1'b0;
    tick();
    chk("rst_release.ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    check_all("rst_release");
    bus.stall = 1'b0;

    // Random traffic with occasional stalls, flushes and resets.
    for (int n = 0; n < 300; n++) begin
      rand_id();
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 5) == 0);
      set_fwd(5'($urandom_range(0, 3)), 1'($urandom), $urandom,
              5'($urandom_range(0, 3)), 1'($urandom), $urandom);
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        m = empty_slot();
        #1;
        check_all("rand_rst");
      end
      tick();
      reset = 1'b0;
      check_all("rand");
      set_fwd(5'($urandom_range(0, 3)), 1'($urandom), $urandom,
              5'($urandom_range(0, 3)), 1'($urandom), $urandom);
      #1;
      check_all("rand_fwd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter OPCODE_LENGTH, default 4, ALU operation code width.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold all pipeline registers.
REQ-006 SHALL have port flush  input  1  load a bubble on next edge.
REQ-007 SHALL have port id_pc  input  DATA_WIDTH  decode-stage PC.
REQ-008 SHALL have port id_rd1  input  DATA_WIDTH  register-file read data, rs1.
REQ-009 SHALL have port id_rd2  input  DATA_WIDTH  register-file read data, rs2.
REQ-010 SHALL have port id_imm  input  DATA_WIDTH  sign-extended immediate.
REQ-011 SHALL have port id_rs1  input  5  source register 1 index.
REQ-012 SHALL have port id_rs2  input  5  source register 2 index.
REQ-013 SHALL have port id_rd  input  5  destination register index.
REQ-014 SHALL have port id_alu_op  input  OPCODE_LENGTH  ALU operation code.
REQ-015 SHALL have port id_asel_pc  input  1  SrcA = PC (AUIPC/JAL).
REQ-016 SHALL have port id_bsel_imm  input  1  SrcB = immediate.
REQ-017 SHALL have port id_regwrite  input  1  instruction writes rd.
REQ-018 SHALL have port mem_fwd_rd  input  5  MEM-stage destination index.
REQ-019 SHALL have port mem_fwd_we  input  1  MEM-stage writes rd.
REQ-020 SHALL have port mem_fwd_data  input  DATA_WIDTH  MEM-stage result.
REQ-021 SHALL have port wb_fwd_rd  input  5  WB-stage destination index.
REQ-022 SHALL have port wb_fwd_we  input  1  WB-stage writes rd.
REQ-023 SHALL have port wb_fwd_data  input  DATA_WIDTH  WB-stage result.
REQ-024 SHALL have port ex_valid  output  1  EX stage holds a real instruction.
REQ-025 SHALL have port SrcA  output  DATA_WIDTH  ALU operand A.
REQ-026 SHALL have port SrcB  output  DATA_WIDTH  ALU operand B.
REQ-027 SHALL have port Operation  output  OPCODE_LENGTH  ALU operation code.
REQ-028 SHALL have port ex_pc  output  DATA_WIDTH  registered PC, for branch target.
REQ-029 SHALL have port ex_rd  output  5  registered destination index.
REQ-030 SHALL have port ex_regwrite  output  1  registered write enable, gated by ex_valid.
REQ-031 SHALL have port ex_store_data  output  DATA_WIDTH  forwarded rs2 value for stores.

Function
REQ-032 SHALL, each rising clk edge: flush=1 -> bubble (ex_valid=0, regwrite=0, alu_op=4'b0000, other fields unchanged). Else stall=1 -> hold all registers. Else capture all id_* inputs and set ex_valid=1.
REQ-033 SHALL give flush priority over stall when both are asserted in the same cycle.
REQ-034 SHALL compute fwdA combinationally from registered rs1: mem_fwd_we && mem_fwd_rd!=0 && mem_fwd_rd==rs1 -> mem_fwd_data; else same test on WB -> wb_fwd_data; else registered rd1. MEM has priority over WB. Index 0 is never forwarded. fwdB is computed identically from rs2/rd2.
REQ-035 SHALL drive SrcA = asel_pc ? ex_pc : fwdA, SrcB = bsel_imm ? imm : fwdB, and ex_store_data = fwdB regardless of bsel_imm.
REQ-036 SHALL drive Operation = registered alu_op, so a bubble presents AND (4'b0000) and the ALU cannot signal a taken branch.
REQ-037 SHALL have zero-cycle combinational latency from forwarding inputs to SrcA/SrcB. Latency from id_* to ex_* is exactly one cycle.

Reset
REQ-038 SHALL, while reset=1, asynchronously clear all registers to 0 (ex_valid=0, Operation=0, ex_pc=0, ex_rd=0, ex_regwrite=0). Reset SHALL override flush and stall and SHALL abort any held instruction.

Configuration
REQ-039 SHALL, with macro ID_EX_FORWARDING_EN defined, implement REQ-034 forwarding. Without the macro, fwdA=rd1 and fwdB=rd2, the mem_/wb_ forwarding inputs are ignored, and all other behaviour is unchanged.

Verification
REQ-040 SHALL cover: reset asserted mid-stall -> all outputs 0 immediately, and ex_valid=0 after release.
REQ-041 SHALL cover: capture rd1=5, rd2=7, alu_op=0010, bsel_imm=0 -> next cycle SrcA=5, SrcB=7, Operation=0010, ex_valid=1.
REQ-042 SHALL cover: rs1=3, mem_fwd rd=3 data=0x11, wb_fwd rd=3 data=0x22, both we=1 -> SrcA=0x11. With mem_fwd_we=0 -> SrcA=0x22. With rs1=0 -> SrcA=rd1.
REQ-043 SHALL cover: flush=1 and stall=1 in the same cycle -> next cycle ex_valid=0, ex_regwrite=0, Operation=0000.
REQ-044 SHALL cover: stall held 3 cycles with changing id_* -> outputs constant. Release -> the new values are captured on the next edge.
